// File: rtl/wb_bram_arbiter.sv
// Two-master Wishbone arbiter in front of a single BRAM slave port.
// Round-robin on ties, bus lock while the owner holds cyc, and a per-access stall timeout.
module wb_bram_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int SW      = 2,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,

    input  logic [AW-1:0] m0_adr,
    input  logic [DW-1:0] m0_din,
    output logic [DW-1:0] m0_dout,
    input  logic          m0_we,
    input  logic          m0_stb,
    input  logic          m0_cyc,
    input  logic [SW-1:0] m0_sel,
    output logic          m0_ack,
    output logic          m0_err,
    output logic          m0_rty,

    input  logic [AW-1:0] m1_adr,
    input  logic [DW-1:0] m1_din,
    output logic [DW-1:0] m1_dout,
    input  logic          m1_we,
    input  logic          m1_stb,
    input  logic          m1_cyc,
    input  logic [SW-1:0] m1_sel,
    output logic          m1_ack,
    output logic          m1_err,
    output logic          m1_rty,

    output logic [AW-1:0] s_adr,
    output logic [DW-1:0] s_dout,
    input  logic [DW-1:0] s_din,
    output logic [SW-1:0] s_sel,
    output logic          s_we,
    output logic          s_stb,
    output logic          s_cyc,
    input  logic          s_ack,
    input  logic          s_err,
    input  logic          s_rty,

    output logic [1:0]    gnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN0 = 2'd1;
    localparam logic [1:0] S_OWN1 = 2'd2;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic          last_q, last_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          tmo_q, tmo_d;

    logic          own0, own1, owning;
    logic          s_term;
    logic [AW-1:0] sel_adr;
    logic [DW-1:0] sel_din;
    logic [SW-1:0] sel_sel;
    logic          sel_we, sel_stb, sel_cyc;

    always_comb begin
        own0    = (state_q == S_OWN0);
        own1    = (state_q == S_OWN1);
        owning  = own0 | own1;
        s_term  = s_ack | s_err | s_rty;

        sel_adr = own1 ? m1_adr : m0_adr;
        sel_din = own1 ? m1_din : m0_din;
        sel_sel = own1 ? m1_sel : m0_sel;
        sel_we  = own1 ? m1_we  : m0_we;
        sel_stb = own1 ? m1_stb : m0_stb;
        sel_cyc = own1 ? m1_cyc : m0_cyc;
    end

    // Arbitration: owner keeps the bus while its cyc stays high, then hands over directly.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    state_d = last_q ? S_OWN0 : S_OWN1;
                end else if (m0_cyc) begin
                    state_d = S_OWN0;
                end else if (m1_cyc) begin
                    state_d = S_OWN1;
                end
            end
            S_OWN0: begin
                if (!m0_cyc) begin
                    last_d  = 1'b0;
                    state_d = m1_cyc ? S_OWN1 : S_IDLE;
                end
            end
            S_OWN1: begin
                if (!m1_cyc) begin
                    last_d  = 1'b1;
                    state_d = m0_cyc ? S_OWN0 : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Stall counter; a slave termination in the expiry cycle beats the synthesized error.
    always_comb begin
        cnt_d = 8'd0;
        tmo_d = 1'b0;
        if (owning && (state_d == state_q) && !tmo_q && sel_stb && !s_term) begin
            if (cnt_q == TMO_LAST) begin
                tmo_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        gnt     = {own1, own0};

        s_adr   = owning ? sel_adr : '0;
        s_dout  = owning ? sel_din : '0;
        s_sel   = owning ? sel_sel : '0;
        s_we    = owning & sel_we;
        s_stb   = owning & sel_stb & ~tmo_q;
        s_cyc   = owning & sel_cyc & ~tmo_q;

        m0_dout = own0 ? s_din : '0;
        m1_dout = own1 ? s_din : '0;

        // During the expiry cycle only the synthesized error reaches the owner.
        m0_ack  = own0 & ~tmo_q & s_ack;
        m0_rty  = own0 & ~tmo_q & s_rty;
        m0_err  = own0 & (tmo_q | s_err);
        m1_ack  = own1 & ~tmo_q & s_ack;
        m1_rty  = own1 & ~tmo_q & s_rty;
        m1_err  = own1 & (tmo_q | s_err);
    end

endmodule

// File: tb/tb_wb_bram_arbiter.sv
// Scoreboard bench for wb_bram_arbiter: directed master accesses against a BRAM slave stub.
module tb_wb_bram_arbiter;

    localparam logic [1:0] K_ACK = 2'd1;
    localparam logic [1:0] K_ERR = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic        chk;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;

    logic [15:0] m_adr  [2];
    logic [15:0] m_din  [2];
    logic [15:0] m_dout [2];
    logic        m_we   [2];
    logic        m_stb  [2];
    logic        m_cyc  [2];
    logic [1:0]  m_sel  [2];
    logic        m_ack  [2];
    logic        m_err  [2];
    logic        m_rty  [2];

    logic [15:0] s_adr, s_dout, s_din;
    logic [1:0]  s_sel;
    logic        s_we, s_stb, s_cyc, s_ack, s_err, s_rty;
    logic [1:0]  gnt;

    logic [15:0] mem [0:255];
    logic        s_ack_q;
    logic [15:0] s_rd_q;
    logic        slave_noack;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    wb_bram_arbiter #(.AW(16), .DW(16), .SW(2), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .m0_adr(m_adr[0]), .m0_din(m_din[0]), .m0_dout(m_dout[0]), .m0_we(m_we[0]),
        .m0_stb(m_stb[0]), .m0_cyc(m_cyc[0]), .m0_sel(m_sel[0]),
        .m0_ack(m_ack[0]), .m0_err(m_err[0]), .m0_rty(m_rty[0]),
        .m1_adr(m_adr[1]), .m1_din(m_din[1]), .m1_dout(m_dout[1]), .m1_we(m_we[1]),
        .m1_stb(m_stb[1]), .m1_cyc(m_cyc[1]), .m1_sel(m_sel[1]),
        .m1_ack(m_ack[1]), .m1_err(m_err[1]), .m1_rty(m_rty[1]),
        .s_adr(s_adr), .s_dout(s_dout), .s_din(s_din), .s_sel(s_sel),
        .s_we(s_we), .s_stb(s_stb), .s_cyc(s_cyc),
        .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty),
        .gnt(gnt)
    );

    // BRAM stub: single-beat registered ack, optionally silent to provoke a timeout.
    assign s_ack = s_ack_q;
    assign s_din = s_rd_q;
    assign s_err = 1'b0;
    assign s_rty = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            s_ack_q <= 1'b0;
        end else if (s_cyc && s_stb && !s_ack_q && !slave_noack) begin
            s_ack_q <= 1'b1;
            s_rd_q  <= mem[s_adr[7:0]];
            if (s_we && s_sel[0]) mem[s_adr[7:0]][7:0]  <= s_dout[7:0];
            if (s_we && s_sel[1]) mem[s_adr[7:0]][15:8] <= s_dout[15:8];
        end else begin
            s_ack_q <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic push(input int m, input logic [1:0] kind, input logic chk, input logic [15:0] data);
        exp_t e;
        e.kind = kind;
        e.chk  = chk;
        e.data = data;
        if (m == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic start(input int m, input logic we, input logic [15:0] adr,
                         input logic [15:0] dat, input logic [1:0] sel);
        m_cyc[m] = 1'b1;
        m_stb[m] = 1'b1;
        m_we[m]  = we;
        m_adr[m] = adr;
        m_din[m] = dat;
        m_sel[m] = sel;
    endtask

    // Waits for any termination to master m, then drops stb (and cyc unless keep).
    task automatic wait_term(input int m, input logic keep);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (m_ack[m] || m_err[m] || m_rty[m]) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL term_timeout m%0d: got no termination required one within 64 cycles", m);
        end
        @(posedge clk);
        #1;
        m_stb[m] = 1'b0;
        if (!keep) begin
            m_cyc[m] = 1'b0;
            m_we[m]  = 1'b0;
        end
    endtask

    // Both masters raise cyc together; the winner must hand over to the loser with no idle gap.
    task automatic tie_check(input logic [1:0] win_gnt, input logic [15:0] a0, input logic [15:0] a1);
        int          w, l;
        logic [1:0]  lose_gnt;
        w        = win_gnt[1] ? 1 : 0;
        l        = 1 - w;
        lose_gnt = {win_gnt[0], win_gnt[1]};
        push(0, K_ACK, 1'b0, 16'h0000);
        push(1, K_ACK, 1'b0, 16'h0000);
        @(posedge clk);
        #1;
        start(0, 1'b1, a0, 16'h1000 + a0, 2'b11);
        start(1, 1'b1, a1, 16'h1000 + a1, 2'b11);
        @(negedge clk);
        check("tie_idle_gnt", 32'(gnt), 32'(2'b00));
        @(negedge clk);
        check("tie_win_gnt", 32'(gnt), 32'(win_gnt));
        fork
            begin
                wait_term(w, 1'b0);
                @(negedge clk);
                check("tie_release_gnt", 32'(gnt), 32'(win_gnt));
                @(negedge clk);
                check("tie_handover_gnt", 32'(gnt), 32'(lose_gnt));
            end
            begin
                wait_term(l, 1'b0);
            end
        join
    endtask

    // Monitor: every termination is matched against the head of that master's queue.
    always @(negedge clk) begin
        int         nterm;
        logic [1:0] got;
        exp_t       e;
        nterm = 0;
        for (int m = 0; m < 2; m++) begin
            nterm += int'(m_ack[m]) + int'(m_err[m]) + int'(m_rty[m]);
        end
        if (nterm > 0) check("one_term", 32'(nterm), 32'd1);
        for (int m = 0; m < 2; m++) begin
            if (m_ack[m] || m_err[m] || m_rty[m]) begin
                got = m_ack[m] ? 2'd1 : (m_err[m] ? 2'd2 : 2'd3);
                if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_term m%0d: got kind %0d required none", m, got);
                end else begin
                    if (m == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    check("term_kind", 32'(got), 32'(e.kind));
                    if (e.chk) check("rd_data", 32'(m_dout[m]), 32'(e.data));
                    check("term_gnt", 32'(gnt), (m == 0) ? 32'd1 : 32'd2);
                    check("other_dout", 32'(m_dout[1 - m]), 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test required end before 200000");
        $fatal(1);
    end

    initial begin
        int t0, te;
        rst         = 1'b1;
        slave_noack = 1'b0;
        for (int m = 0; m < 2; m++) begin
            m_adr[m] = '0; m_din[m] = '0; m_we[m] = 1'b0;
            m_stb[m] = 1'b0; m_cyc[m] = 1'b0; m_sel[m] = '0;
        end
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 4; i++) mem[16 + i] = 16'hA010 + 16'(i);

        // Reset state
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_s_cyc", 32'(s_cyc), 32'd0);
        check("rst_s_stb", 32'(s_stb), 32'd0);
        check("rst_m0_ack", 32'(m_ack[0]), 32'd0);
        check("rst_m1_dout", 32'(m_dout[1]), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // First tie after reset goes to m0; next tie also goes to m0 after m1 was last
        tie_check(2'b01, 16'h0001, 16'h0002);
        tie_check(2'b01, 16'h0003, 16'h0004);

        // m0 single write then read-back
        push(0, K_ACK, 1'b0, 16'h0000);
        @(posedge clk);
        #1;
        start(0, 1'b1, 16'h0000, 16'hDEAD, 2'b11);
        @(negedge clk);
        check("wr_idle_gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        check("wr_gnt", 32'(gnt), 32'd1);
        check("wr_s_stb", 32'(s_stb), 32'd1);
        check("wr_s_dout", 32'(s_dout), 32'hDEAD);
        check("wr_s_we", 32'(s_we), 32'd1);
        wait_term(0, 1'b0);
        push(0, K_ACK, 1'b1, 16'hDEAD);
        @(posedge clk);
        #1;
        start(0, 1'b0, 16'h0000, 16'h0000, 2'b11);
        wait_term(0, 1'b0);

        // m0 was last, so a tie now favours m1
        tie_check(2'b10, 16'h0005, 16'h0006);

        // m1 locks the bus for four reads while m0 waits
        for (int i = 0; i < 4; i++) push(1, K_ACK, 1'b1, 16'hA010 + 16'(i));
        @(posedge clk);
        #1;
        start(1, 1'b0, 16'h0010, 16'h0000, 2'b11);
        @(posedge clk);
        #1;
        start(0, 1'b1, 16'h0020, 16'h2020, 2'b11);
        wait_term(1, 1'b1);
        for (int i = 1; i < 4; i++) begin
            start(1, 1'b0, 16'h0010 + 16'(i), 16'h0000, 2'b11);
            wait_term(1, (i < 3) ? 1'b1 : 1'b0);
        end
        push(0, K_ACK, 1'b0, 16'h0000);
        @(negedge clk);
        check("lock_release_gnt", 32'(gnt), 32'd2);
        @(negedge clk);
        check("lock_handover_gnt", 32'(gnt), 32'd1);
        wait_term(0, 1'b0);

        // Silent slave: m0 gets one synthesized err 8 cycles after the first strobe
        slave_noack = 1'b1;
        push(0, K_ERR, 1'b0, 16'h0000);
        @(posedge clk);
        #1;
        start(0, 1'b1, 16'h0005, 16'h5555, 2'b11);
        t0 = -1;
        te = -1;
        for (int k = 0; k < 30 && te < 0; k++) begin
            @(negedge clk);
            if (s_stb && t0 < 0) t0 = k;
            if (m_err[0]) begin
                te = k;
                check("tmo_s_stb", 32'(s_stb), 32'd0);
                check("tmo_s_cyc", 32'(s_cyc), 32'd0);
            end
        end
        check("tmo_delay", 32'(te - t0), 32'd8);
        @(negedge clk);
        check("tmo_err_once", 32'(m_err[0]), 32'd0);
        check("tmo_stb_back", 32'(s_stb), 32'd1);
        @(posedge clk);
        #1;
        m_stb[0] = 1'b0;
        m_cyc[0] = 1'b0;
        m_we[0]  = 1'b0;

        // Reset in the middle of an m1 access
        @(posedge clk);
        #1;
        start(1, 1'b0, 16'h0011, 16'h0000, 2'b11);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_gnt", 32'(gnt), 32'd2);
        check("pre_rst_s_cyc", 32'(s_cyc), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_s_cyc", 32'(s_cyc), 32'd0);
        check("mid_rst_s_stb", 32'(s_stb), 32'd0);
        check("mid_rst_gnt", 32'(gnt), 32'd0);
        check("mid_rst_m1_ack", 32'(m_ack[1]), 32'd0);
        @(posedge clk);
        #1;
        m_stb[1]    = 1'b0;
        m_cyc[1]    = 1'b0;
        rst         = 1'b0;
        slave_noack = 1'b0;
        tie_check(2'b01, 16'h0007, 16'h0008);

        repeat (3) @(negedge clk);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_bram_arbiter.md
WB_BRAM_ARBITER -- requirements
Module: wb_bram_arbiter

Interface
REQ-001 Parameter AW, default 16, address width.
REQ-002 Parameter DW, default 16, data width.
REQ-003 Parameter SW, default 2, byte-select width.
REQ-004 Parameter TIMEOUT, default 255, range 1..255, max cycles a strobed access waits for slave termination.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 mN_adr (N=0,1)  in  AW  master N address.
REQ-008 mN_din  in  DW  master N write data.
REQ-009 mN_dout  out  DW  read data to master N.
REQ-010 mN_we, mN_stb, mN_cyc  in  1 each  master N write enable, strobe, cycle.
REQ-011 mN_sel  in  SW  master N byte selects.
REQ-012 mN_ack, mN_err, mN_rty  out  1 each  master N terminations.
REQ-013 s_adr  out  AW;  s_dout  out  DW (write data);  s_din  in  DW (read data);  s_sel  out  SW.
REQ-014 s_we, s_stb, s_cyc  out  1 each;  s_ack, s_err, s_rty  in  1 each  shared BRAM slave port.
REQ-015 gnt  out  2  one-hot current owner; 2'b00 when idle.

Function
REQ-016 FSM states IDLE, OWN0, OWN1; gnt = {state==OWN1, state==OWN0}.
REQ-017 Request of master N = mN_cyc; mN_stb without mN_cyc is ignored.
REQ-018 IDLE: one request -> OWN of that master next cycle; both -> OWN of the master not equal to register last; none -> stay.
REQ-019 Grant registered: slave sees first strobe one cycle after cyc assertion from IDLE.
REQ-020 OWNn: s_adr/s_dout/s_sel/s_we/s_stb/s_cyc = master n signals, combinational; mn_dout = s_din; mn_ack/err/rty = s_ack/err/rty.
REQ-021 Non-owner: dout = 0, ack/err/rty = 0; IDLE: all slave outputs 0.
REQ-022 Ownership held while owner cyc high, across multiple stb/ack beats (bus lock).
REQ-023 OWNn with mn_cyc low: last <= n; other master requesting -> OWN other next cycle (direct handover, no IDLE cycle); else -> IDLE.
REQ-024 Timeout counter, 8 bits: cleared on entry to OWNn, on any of s_ack/s_err/s_rty, and when s_stb low; increments each OWNn cycle with s_stb high and no slave termination.
REQ-025 Counter reaching TIMEOUT-1 with no termination: next cycle s_stb and s_cyc forced 0, mn_err = 1 for exactly that cycle, counter cleared; ownership retained while mn_cyc high.
REQ-026 Slave termination arriving in the same cycle as timeout expiry wins: terminations passed through, no synthesized err.
REQ-027 Never more than one mN_ack/err/rty high in any cycle; slave terminations only reach the current owner.

Reset
REQ-028 rst high at clock edge: state IDLE, last = 1 (m0 wins first tie), counter 0, gnt = 0.
REQ-029 During and after reset until next grant: all s_* outputs and mN_* outputs 0.
REQ-030 rst mid-transfer: s_cyc/s_stb drop after that edge, in-flight access abandoned, no termination to master; arbitration restarts from IDLE when rst low.

Verification
REQ-031 m0 single write adr 0x0000 data 0xDEAD sel 2'b11, m1 idle -> gnt 01 one cycle after m0_cyc, m0_ack once, read-back returns 0xDEAD on m0_dout, m1_dout = 0.
REQ-032 m0, m1 assert cyc same cycle after reset -> m0 granted first; after m0 releases, m1 granted next cycle with no IDLE gap; next tie -> m0 (round-robin).
REQ-033 m1 locks bus for 4 back-to-back reads adr 0x0010..0x0013 while m0 requests -> m0 stalled, gnt stays 10 until m1_cyc low; m0 never sees ack.
REQ-034 Slave stub never acks, TIMEOUT=8, m0 strobes -> m0_err high exactly one cycle, 8 cycles after first s_stb; s_stb low that cycle.
REQ-035 rst asserted mid-transfer of m1 -> s_cyc 0 next cycle, gnt 00, no m1_ack; after release, tie grants m0.
